// File: rtl/image_pixel_pipe.sv
// Two-stage pixel datapath: per-lane darken/lighten/invert with optional
// saturation, plus a frame-spanning XOR checksum and an output frame counter.

module image_pixel_lane (
    input  logic [7:0] p_i,
    input  logic [7:0] delta_i,
    input  logic [1:0] op_i,
    input  logic       sat_i,
    output logic [7:0] r_o
);
    logic [8:0] sum_d;
    logic [8:0] dif_d;

    always_comb begin
        sum_d = {1'b0, p_i} + {1'b0, delta_i};
        dif_d = {1'b0, p_i} - {1'b0, delta_i};
        r_o   = 8'h00;
        case (op_i)
            2'b00:   r_o = (sat_i && dif_d[8]) ? 8'h00 : dif_d[7:0];
            2'b01:   r_o = (sat_i && sum_d[8]) ? 8'hFF : sum_d[7:0];
            2'b10:   r_o = 8'hFF - p_i;
            default: r_o = 8'h00;
        endcase
    end
endmodule

module image_pixel_pipe #(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_LANES-1:0] in_data,
    input  logic [1:0]             in_op,
    input  logic [7:0]             in_delta,
    input  logic                   in_sat,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_LANES-1:0] out_data,
    output logic                   out_last,
    output logic [CNT_W-1:0]       frame_count
);
    localparam int W = 8 * NUM_LANES;
    localparam logic [1:0] OP_CKSM = 2'b11;

    logic             s1_vld_q;
    logic [W-1:0]     s1_data_q;
    logic [1:0]       s1_op_q;
    logic [7:0]       s1_delta_q;
    logic             s1_sat_q;
    logic             s1_last_q;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic             out_last_q;
    logic [7:0]       acc_q;
    logic [CNT_W-1:0] frame_q;

    logic             adv;
    logic [W-1:0]     lane_res;
    logic [7:0]       beat_x;
    logic [W-1:0]     res_d;
    logic             is_cksm;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign is_cksm  = (s1_op_q == OP_CKSM);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        image_pixel_lane u_lane (
            .p_i    (s1_data_q[8*i +: 8]),
            .delta_i(s1_delta_q),
            .op_i   (s1_op_q),
            .sat_i  (s1_sat_q),
            .r_o    (lane_res[8*i +: 8])
        );
    end

    always_comb begin
        beat_x = 8'h00;
        for (int i = 0; i < NUM_LANES; i++) begin
            beat_x = beat_x ^ s1_data_q[8*i +: 8];
        end
        res_d = is_cksm ? W'(acc_q ^ beat_x) : lane_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_op_q     <= 2'b00;
            s1_delta_q  <= 8'h00;
            s1_sat_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            acc_q       <= 8'h00;
            frame_q     <= '0;
        end else begin
            if (out_valid_q && out_ready && out_last_q) begin
                frame_q <= frame_q + CNT_W'(1);
            end
            if (adv) begin
                s1_vld_q   <= in_valid;
                s1_data_q  <= in_data;
                s1_op_q    <= in_op;
                s1_delta_q <= in_delta;
                s1_sat_q   <= in_sat;
                s1_last_q  <= in_last;
                // Non-last checksum beats only fold into acc; they emit nothing.
                out_valid_q <= s1_vld_q && !(is_cksm && !s1_last_q);
                out_last_q  <= s1_vld_q && s1_last_q;
                if (s1_vld_q && !(is_cksm && !s1_last_q)) begin
                    out_data_q <= res_d;
                end
                if (s1_vld_q) begin
                    if (s1_last_q)    acc_q <= 8'h00;
                    else if (is_cksm) acc_q <= acc_q ^ beat_x;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign frame_count = frame_q;
endmodule

// File: tb/tb_image_pixel_pipe.sv
// Scoreboard bench for image_pixel_pipe: directed beats push expected results,
// an independent monitor pops and compares on every output transfer.

module tb_image_pixel_pipe;
    localparam int NL = 4;
    localparam int W  = 8 * NL;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [1:0]   in_op = 2'b00;
    logic [7:0]   in_delta = 8'h00;
    logic         in_sat = 1'b0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [15:0]  frame_count;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_fc = 0;
    int n_out  = 0;

    logic [W-1:0] exp_data_q[$];
    bit           exp_last_q[$];

    image_pixel_pipe #(.NUM_LANES(NL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_op(in_op), .in_delta(in_delta), .in_sat(in_sat), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on each output transfer; also watch stall behaviour.
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_data;
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) check("stall_data_stable", out_data, stall_data);
            if (out_valid && !out_ready) check("in_ready_low_on_stall", {31'b0, in_ready}, 32'd0);
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_data_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    logic [W-1:0] ed;
                    bit el;
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("out_data", out_data, ed);
                    check("out_last", {31'b0, out_last}, {31'b0, el});
                    if (el) exp_fc++;
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Issue one beat; hold until accepted (bounded). Called at posedge+#1.
    task automatic send(input logic [W-1:0] d, input logic [1:0] op, input logic [7:0] dl,
                        input logic sat, input logic last, input bit has_out, input logic [W-1:0] exp);
        bit acc;
        int guard;
        in_valid = 1'b1; in_data = d; in_op = op; in_delta = dl; in_sat = sat; in_last = last;
        if (has_out) begin
            exp_data_q.push_back(exp);
            exp_last_q.push_back(last);
        end
        acc = 0; guard = 0;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: got not accepted expected accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_data_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_data_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", {31'b0, out_last}, 0);
        check("rst_frame_count", {16'b0, frame_count}, 0);
        @(negedge clk); rst = 1'b0;
        #1 check("in_ready_after_rst", {31'b0, in_ready}, 1);
        @(posedge clk); #1;

        // DARK / LITE / INVT, back-to-back
        send(32'h10_40_80_FF, 2'b00, 8'h1F, 1'b0, 1'b0, 1, 32'hF1_21_61_E0);
        send(32'h10_40_80_FF, 2'b00, 8'h1F, 1'b1, 1'b0, 1, 32'h00_21_61_E0);
        send(32'hF0_10_E1_00, 2'b01, 8'h1F, 1'b1, 1'b0, 1, 32'hFF_2F_FF_1F);
        send(32'hF0_10_E1_00, 2'b01, 8'h1F, 1'b0, 1'b0, 1, 32'h0F_2F_00_1F);
        send(32'h00_FF_5A_A5, 2'b10, 8'h33, 1'b1, 1'b0, 1, 32'hFF_00_A5_5A);
        drain();
        check("fc_before_cksm", {16'b0, frame_count}, 0);

        // 3-beat checksum frame, then a fresh 1-beat frame
        send(32'h01020304, 2'b11, 8'h00, 1'b0, 1'b0, 0, 0);
        send(32'h10203040, 2'b11, 8'h00, 1'b0, 1'b0, 0, 0);
        send(32'hFFFFFFFF, 2'b11, 8'h00, 1'b0, 1'b1, 1, 32'h00000044);
        drain();
        check("fc_after_cksm", {16'b0, frame_count}, 1);
        send(32'h000000AA, 2'b11, 8'h00, 1'b0, 1'b1, 1, 32'h000000AA);
        drain();
        check("fc_after_cksm2", {16'b0, frame_count}, 2);

        // Non-CKSM last beat clears acc
        send(32'h0000000F, 2'b11, 8'h00, 1'b0, 1'b0, 0, 0);
        send(32'h01_02_03_04, 2'b10, 8'h00, 1'b0, 1'b1, 1, 32'hFE_FD_FC_FB);
        send(32'h00000005, 2'b11, 8'h00, 1'b0, 1'b1, 1, 32'h00000005);
        drain();
        check("fc_mixed", {16'b0, frame_count}, 4);
        check("fc_model", {16'b0, frame_count}, exp_fc);

        // Backpressure: out_ready low on cycles 3-5 of an 8-beat INVT stream
        n_before = n_out;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] d;
            d = {4{8'(i * 17 + 3)}};
            send(d, 2'b10, 8'h00, 1'b0, 1'b0, 1, ~d);
        end
        drain();
        check("bp_count", n_out - n_before, 8);

        // Reset in the middle of a checksum frame
        send(32'h11223344, 2'b11, 8'h00, 1'b0, 1'b0, 0, 0);
        send(32'h55667788, 2'b11, 8'h00, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        #2;
        check("midrst_frame_count", {16'b0, frame_count}, 0);
        check("midrst_out_valid", {31'b0, out_valid}, 0);
        check("midrst_out_data", out_data, 0);
        exp_fc = 0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send(32'h00000011, 2'b11, 8'h00, 1'b0, 1'b1, 1, 32'h00000011);
        drain();
        check("fc_after_midrst", {16'b0, frame_count}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/image_pixel_pipe.md
Name: image_pixel_pipe

Overview:
- Parametrised, pipelined successor to the team's 32-bit pixel-op datapath.
- Applies darken, lighten, invert or frame-checksum to NUM_LANES 8-bit pixels per beat.
- Adds a programmable delta, optional saturation, valid/ready handshakes on both sides, a frame-spanning XOR checksum and a frame counter.
- Sits between the image DMA read stream and the writeback stream.

Parameters:
- NUM_LANES, 4, number of 8-bit pixel lanes per beat (1..16); data width W = 8*NUM_LANES.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  W  pixels; lane i occupies bits [8i+7:8i].
- in_op  in  2  per-beat operation: 00 DARK, 01 LITE, 10 INVT, 11 CKSM.
- in_delta  in  8  per-beat delta for DARK/LITE.
- in_sat  in  1  1 = saturate DARK/LITE; 0 = modulo-256 wrap.
- in_last  in  1  last beat of frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  result; lane i at bits [8i+7:8i].
- out_last  out  1  last beat of frame.
- frame_count  out  CNT_W  number of frames completed at the output.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, frame_count=0, checksum accumulator=0, both pipeline stages empty. in_ready is 1 in the first cycle after reset deasserts.
- Transfers: an input transfer occurs when in_valid&in_ready; an output transfer occurs when out_valid&out_ready.
- Pipeline: two register stages, S1 (capture) and S2 (compute/output).
  - Stage advance: adv = !out_valid | out_ready.
  - in_ready = adv; it is registered-free and combinational from out_valid/out_ready.
  - When adv=0, both stages hold and no beat is lost or duplicated.
- Latency: an accepted beat appears on out_* exactly 2 cycles later when out_ready stays 1. Throughput is 1 beat/cycle.
- Bubbles: if S1 holds no beat when S2 advances, out_valid deasserts.
- DARK, per lane: p - delta.
  - sat=1: a borrow clamps the result to 8'h00.
  - sat=0: 8-bit wrap.
- LITE, per lane: p + delta.
  - sat=1: a carry clamps the result to 8'hFF.
  - sat=0: 8-bit wrap.
- INVT, per lane: 8'hFF - p. delta and sat are ignored.
- CKSM:
  - beat_x = XOR of all lanes of the beat.
  - Non-last CKSM beat: acc <= acc ^ beat_x; no output beat is produced.
  - Last CKSM beat: produces one output beat with lane 0 = acc ^ beat_x, all other lanes 0, out_last=1; acc <= 0 in the same cycle.
- Mixed-op frames: op is per beat. Non-CKSM beats pass through with the selected op and leave acc untouched. A non-CKSM last beat also clears acc.
- out_last: mirrors in_last of the beat that produced the output.
- frame_count: increments by 1 on each output transfer with out_last=1 and wraps at 2^CNT_W.
- Reset mid-frame: the partial frame and acc are discarded and the outputs return to their reset values immediately.
- NUM_LANES=1: CKSM output equals acc ^ p.

Test Plan:
- Reset, then NUM_LANES=4 DARK, delta=8'h1F, sat=0, data=32'h10_40_80_FF → 2 cycles later out_data=32'hF1_21_61_E0, out_last mirrors in_last.
- Same data with sat=1 → 32'h00_21_61_E0. Then LITE, delta=8'h1F, sat=1, data=32'hF0_10_E1_00 → 32'hFF_2F_FF_1F; with sat=0 → 32'h0F_2F_00_1F.
- INVT on 32'h00_FF_5A_A5 → 32'hFF_00_A5_5A.
- CKSM frame of 3 beats 32'h01020304, 32'h10203040, 32'hFFFFFFFF (last) → exactly one output beat 32'h00000044 with out_last=1, frame_count 0→1. A following 1-beat CKSM frame 32'h000000AA → 32'h000000AA (acc was cleared).
- Backpressure: stream 8 INVT beats with out_ready low on cycles 3-5 → in_ready low in those cycles, all 8 results in order, none dropped or duplicated, out_data stable while out_valid&!out_ready.
- Assert rst after the 2nd beat of a 4-beat CKSM frame, then send a 1-beat CKSM frame 32'h00000011 → output 32'h00000011 and frame_count=1.
